// File: rtl/unstrip_pkg.sv
// Shared types and constants for the two-lane unstripe scheduler.
package unstrip_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ERR_CNT_W  = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/lane_fifo.sv
// Small first-word-fall-through FIFO for one lane; the head word is readable
// combinationally so the scheduler's output register is the only pipeline stage.
module lane_fifo #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/unstrip_scheduler.sv
// Recombines two striped lanes into one ordered stream by popping the lane
// FIFOs in strict alternation; a lane overflow forces a one-cycle flush.
module unstrip_scheduler
    import unstrip_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_2f,
    input  logic                 reset_L,
    input  logic                 valid_0,
    input  logic [DATA_W-1:0]    lane_0,
    input  logic                 valid_1,
    input  logic [DATA_W-1:0]    lane_1,
    input  logic                 out_ready,
    output logic                 ready_0,
    output logic                 ready_1,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid_out,
    output logic                 skew_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sel;
    logic                 w_sel_next;
    logic [DATA_W-1:0]    r_data_out;
    logic                 r_valid_out;
    logic                 r_skew_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [1:0]           w_in_valid;
    logic [DATA_W-1:0]    w_in_data  [2];
    logic [DATA_W-1:0]    w_rd_data  [2];
    logic [CNT_W-1:0]     w_count    [2];
    logic [1:0]           w_full;
    logic [1:0]           w_empty;
    logic [1:0]           w_ready;
    logic [1:0]           w_push;
    logic [1:0]           w_pop;
    logic [1:0]           w_ovf;
    logic                 w_overflow;
    logic                 w_flushing;
    logic                 w_fifo_clr;
    logic                 w_adv;
    logic                 w_both_empty;
    logic                 w_load;
    logic                 w_pop_lane;

    assign w_in_valid   = {valid_1, valid_0};
    assign w_in_data[0] = lane_0;
    assign w_in_data[1] = lane_1;

    assign w_flushing   = (r_state == FLUSH);
    assign w_fifo_clr   = !reset_L || w_flushing;
    assign w_adv        = !r_valid_out || out_ready;
    assign w_both_empty = (w_count[0] == '0) && (w_count[1] == '0);
    assign w_overflow   = |w_ovf;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign w_ready[gi] = reset_L && !w_flushing && !w_full[gi];
            assign w_push[gi]  = w_in_valid[gi] && w_ready[gi];
            // A word offered to a full FIFO is dropped and triggers resync.
            assign w_ovf[gi]   = reset_L && !w_flushing && w_in_valid[gi] && w_full[gi];

            lane_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk_2f),
                .i_clr   (w_fifo_clr),
                .i_push  (w_push[gi]),
                .i_data  (w_in_data[gi]),
                .i_pop   (w_pop[gi]),
                .o_data  (w_rd_data[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi]),
                .o_count (w_count[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_pop        = '0;
        w_load       = 1'b0;
        w_pop_lane   = r_sel;
        case (r_state)
            IDLE: begin
                w_sel_next = 1'b0;
                // A pair starts only once both lanes have data, absorbing skew.
                if (!w_empty[0] && !w_empty[1] && w_adv) begin
                    w_pop[0]     = 1'b1;
                    w_load       = 1'b1;
                    w_pop_lane   = 1'b0;
                    w_sel_next   = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!w_empty[r_sel] && w_adv) begin
                    w_pop[r_sel] = 1'b1;
                    w_load       = 1'b1;
                    w_sel_next   = !r_sel;
                end else if (!r_sel && w_both_empty && w_adv) begin
                    w_state_next = IDLE;
                end
            end
            FLUSH: begin
                w_sel_next   = 1'b0;
                w_state_next = IDLE;
            end
            default: begin
                w_sel_next   = 1'b0;
                w_state_next = IDLE;
            end
        endcase
        if (w_overflow) begin
            w_state_next = FLUSH;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            r_state     <= IDLE;
            r_sel       <= 1'b0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_skew_err  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_skew_err <= w_overflow;
            if (w_flushing) begin
                r_valid_out <= 1'b0;
                if (r_err_cnt != ERR_CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else if (w_load) begin
                r_data_out  <= w_rd_data[w_pop_lane];
                r_valid_out <= 1'b1;
            end else if (out_ready) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign ready_0   = w_ready[0];
    assign ready_1   = w_ready[1];
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign skew_err  = r_skew_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_unstrip_scheduler.sv
// Directed bench for unstrip_scheduler: each vector drives one cycle and checks
// the registered outputs 1 ns after the clock edge against hand-derived values.
module tb_unstrip_scheduler;

    logic        clk_2f = 1'b0;
    logic        reset_L;
    logic        valid_0;
    logic [31:0] lane_0;
    logic        valid_1;
    logic [31:0] lane_1;
    logic        out_ready;
    logic        ready_0;
    logic        ready_1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        skew_err;
    logic [7:0]  err_cnt;

    int checks      = 0;
    int failures    = 0;
    int skew_pulses = 0;

    always #5 clk_2f = ~clk_2f;

    unstrip_scheduler #(
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_2f    (clk_2f),
        .reset_L   (reset_L),
        .valid_0   (valid_0),
        .lane_0    (lane_0),
        .valid_1   (valid_1),
        .lane_1    (lane_1),
        .out_ready (out_ready),
        .ready_0   (ready_0),
        .ready_1   (ready_1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .skew_err  (skew_err),
        .err_cnt   (err_cnt)
    );

    always @(negedge clk_2f) begin
        if (skew_err === 1'b1) begin
            skew_pulses++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v0, input logic [31:0] d0, input logic v1,
                        input logic [31:0] d1, input logic rdy);
        valid_0   = v0;
        lane_0    = d0;
        valid_1   = v1;
        lane_1    = d1;
        out_ready = rdy;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic vec(input string tag, input logic v0, input logic [31:0] d0, input logic v1,
                       input logic [31:0] d1, input logic rdy, input logic ev, input logic [31:0] ed);
        step(v0, d0, v1, d1, rdy);
        $display("%s valid_out=%0b data_out=%h skew_err=%0b err_cnt=%0d",
                 tag, valid_out, data_out, skew_err, err_cnt);
        check_value({tag, "_valid"}, {31'd0, valid_out}, {31'd0, ev});
        if (ev) begin
            check_value({tag, "_data"}, data_out, ed);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_data"},  data_out, 32'd0);
        check_value({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        check_value({tag, "_skew"},  {31'd0, skew_err}, 32'd0);
        check_value({tag, "_errcnt"}, {24'd0, err_cnt}, 32'd0);
        check_value({tag, "_rdy0"},  {31'd0, ready_0}, 32'd0);
        check_value({tag, "_rdy1"},  {31'd0, ready_1}, 32'd0);
    endtask

    initial begin
        reset_L   = 1'b0;
        valid_0   = 1'b0;
        valid_1   = 1'b0;
        lane_0    = '0;
        lane_1    = '0;
        out_ready = 1'b0;

        // Reset state
        step(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1);
        step(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1);
        check_reset_outputs("rst");
        reset_L = 1'b1;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        #1;
        check_value("rst_rel_rdy0", {31'd0, ready_0}, 32'd1);
        check_value("rst_rel_rdy1", {31'd0, ready_1}, 32'd1);

        // Aligned streams: no gaps after the first word
        vec("al0", 1, 32'hA000_0000, 1, 32'hA000_0001, 1, 0, 32'd0);
        vec("al1", 0, 32'd0,         0, 32'd0,         1, 1, 32'hA000_0000);
        vec("al2", 1, 32'hA000_0002, 1, 32'hA000_0003, 1, 1, 32'hA000_0001);
        vec("al3", 0, 32'd0,         0, 32'd0,         1, 1, 32'hA000_0002);
        vec("al4", 1, 32'hA000_0004, 1, 32'hA000_0005, 1, 1, 32'hA000_0003);
        vec("al5", 0, 32'd0,         0, 32'd0,         1, 1, 32'hA000_0004);
        vec("al6", 0, 32'd0,         0, 32'd0,         1, 1, 32'hA000_0005);
        vec("al7", 0, 32'd0,         0, 32'd0,         1, 0, 32'd0);
        check_value("al_skew_pulses", skew_pulses, 0);

        // Skew: lane 1 three cycles late
        vec("sk0", 1, 32'hB000_0000, 0, 32'd0,         1, 0, 32'd0);
        vec("sk1", 0, 32'd0,         0, 32'd0,         1, 0, 32'd0);
        vec("sk2", 1, 32'hB000_0002, 0, 32'd0,         1, 0, 32'd0);
        vec("sk3", 0, 32'd0,         1, 32'hB000_0001, 1, 0, 32'd0);
        vec("sk4", 0, 32'd0,         0, 32'd0,         1, 1, 32'hB000_0000);
        vec("sk5", 0, 32'd0,         1, 32'hB000_0003, 1, 1, 32'hB000_0001);
        vec("sk6", 0, 32'd0,         0, 32'd0,         1, 1, 32'hB000_0002);
        vec("sk7", 0, 32'd0,         0, 32'd0,         1, 1, 32'hB000_0003);
        vec("sk8", 0, 32'd0,         0, 32'd0,         1, 0, 32'd0);
        check_value("sk_skew_pulses", skew_pulses, 0);

        // Backpressure: out_ready low for 5 cycles, FIFOs fill up
        vec("bp0", 1, 32'hC000_0000, 1, 32'hC000_0001, 1, 0, 32'd0);
        vec("bp1", 0, 32'd0,         0, 32'd0,         1, 1, 32'hC000_0000);
        vec("bp2", 1, 32'hC000_0002, 1, 32'hC000_0003, 0, 1, 32'hC000_0000);
        vec("bp3", 1, 32'hC000_0004, 1, 32'hC000_0005, 0, 1, 32'hC000_0000);
        vec("bp4", 1, 32'hC000_0006, 1, 32'hC000_0007, 0, 1, 32'hC000_0000);
        check_value("bp4_rdy0", {31'd0, ready_0}, 32'd1);
        check_value("bp4_rdy1", {31'd0, ready_1}, 32'd0);
        vec("bp5", 1, 32'hC000_0008, 0, 32'd0,         0, 1, 32'hC000_0000);
        check_value("bp5_rdy0", {31'd0, ready_0}, 32'd0);
        check_value("bp5_rdy1", {31'd0, ready_1}, 32'd0);
        vec("bp6", 0, 32'd0,         0, 32'd0,         0, 1, 32'hC000_0000);
        vec("bp7", 0, 32'd0,         0, 32'd0,         1, 1, 32'hC000_0001);
        check_value("bp7_rdy1", {31'd0, ready_1}, 32'd1);
        vec("bp8", 0, 32'd0,         1, 32'hC000_0009, 1, 1, 32'hC000_0002);
        for (int i = 3; i <= 9; i++) begin
            vec($sformatf("bp%0d", i + 6), 0, 32'd0, 0, 32'd0, 1, 1, 32'hC000_0000 + i);
        end
        vec("bp16", 0, 32'd0,        0, 32'd0,         1, 0, 32'd0);
        check_value("bp_skew_pulses", skew_pulses, 0);

        // Overflow on lane 0 with lane 1 idle
        vec("of0", 1, 32'hD000_0000, 0, 32'd0, 1, 0, 32'd0);
        vec("of1", 1, 32'hD000_0001, 0, 32'd0, 1, 0, 32'd0);
        vec("of2", 1, 32'hD000_0002, 0, 32'd0, 1, 0, 32'd0);
        vec("of3", 1, 32'hD000_0003, 0, 32'd0, 1, 0, 32'd0);
        check_value("of3_rdy0", {31'd0, ready_0}, 32'd0);
        check_value("of3_skew", {31'd0, skew_err}, 32'd0);
        vec("of4", 1, 32'hD000_0004, 0, 32'd0, 1, 0, 32'd0);
        check_value("of4_skew", {31'd0, skew_err}, 32'd1);
        check_value("of4_rdy0", {31'd0, ready_0}, 32'd0);
        check_value("of4_errcnt", {24'd0, err_cnt}, 32'd0);
        vec("of5", 0, 32'd0, 0, 32'd0, 1, 0, 32'd0);
        check_value("of5_skew", {31'd0, skew_err}, 32'd0);
        check_value("of5_errcnt", {24'd0, err_cnt}, 32'd1);
        check_value("of5_rdy0", {31'd0, ready_0}, 32'd1);
        check_value("of5_rdy1", {31'd0, ready_1}, 32'd1);
        vec("of6", 1, 32'hE000_0000, 1, 32'hE000_0001, 1, 0, 32'd0);
        vec("of7", 0, 32'd0,         0, 32'd0,         1, 1, 32'hE000_0000);
        vec("of8", 0, 32'd0,         0, 32'd0,         1, 1, 32'hE000_0001);
        vec("of9", 0, 32'd0,         0, 32'd0,         1, 0, 32'd0);
        check_value("of_skew_pulses", skew_pulses, 1);

        // Reset for one cycle in the middle of a stream
        vec("rs0", 1, 32'hF000_0000, 1, 32'hF000_0001, 1, 0, 32'd0);
        vec("rs1", 1, 32'hF000_0002, 1, 32'hF000_0003, 1, 1, 32'hF000_0000);
        reset_L = 1'b0;
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        check_reset_outputs("rs_mid");
        reset_L = 1'b1;
        vec("rs2", 1, 32'h5000_0000, 1, 32'h5000_0001, 1, 0, 32'd0);
        vec("rs3", 0, 32'd0,         0, 32'd0,         1, 1, 32'h5000_0000);
        vec("rs4", 0, 32'd0,         0, 32'd0,         1, 1, 32'h5000_0001);
        vec("rs5", 0, 32'd0,         0, 32'd0,         1, 0, 32'd0);
        check_value("rs_skew_pulses", skew_pulses, 1);

        // Saturation: 260 overflow events, six cycles each
        for (int k = 0; k < 260; k++) begin
            for (int j = 0; j < 5; j++) begin
                step(1'b1, 32'h7000_0000 + k, 1'b0, 32'd0, 1'b1);
            end
            step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
            if (k == 199) begin
                check_value("sat_200", {24'd0, err_cnt}, 32'd200);
            end
        end
        check_value("sat_255", {24'd0, err_cnt}, 32'd255);
        check_value("sat_valid", {31'd0, valid_out}, 32'd0);
        check_value("sat_skew_pulses", skew_pulses, 261);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
